// File: rtl/rv32i_pkg.sv
// Shared RV32I platform constants: data-bus MMIO map, STATUS layout and decode select.
package rv32i_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;
  localparam logic [31:0] MMIO_TXDATA = MMIO_BASE + 32'h00;
  localparam logic [31:0] MMIO_STATUS = MMIO_BASE + 32'h04;
  localparam logic [31:0] MMIO_CYC_LO = MMIO_BASE + 32'h08;
  localparam logic [31:0] MMIO_CYC_HI = MMIO_BASE + 32'h0C;
  localparam logic [31:0] MMIO_HALT   = MMIO_BASE + 32'h10;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_HALT
  } dbus_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is dropped and latches a sticky overflow flag
// unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = buf_q[rd_ptr];

  // Storage is not reset; only pointers and flags are.
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-side bus responder: byte-enabled RAM plus MMIO (TX FIFO, 64-bit cycle counter
// with coherent high-word shadow, sticky halt) behind a combinational read mux.
module dbus_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  input  logic        data_re,
  output logic [31:0] data_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   word_addr;
  logic          ram_hit;
  logic          access;
  dbus_sel_e     sel;

  logic [63:0]   cycle;
  logic [31:0]   cyc_hi_shadow;
  logic [31:0]   status;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;

  assign ram_idx   = data_addr[AW+1:2];
  assign word_addr = {data_addr[31:2], 2'b00};
  assign ram_hit   = (data_addr >> (AW + 2)) == 32'd0;
  assign access    = data_re || (data_we != 4'b0000);

  // Address decode; byte offset bits never affect which register is selected.
  always_comb begin
    sel = SEL_NONE;
    if (ram_hit) begin
      sel = SEL_RAM;
    end else begin
      case (word_addr)
        MMIO_TXDATA: sel = SEL_TXDATA;
        MMIO_STATUS: sel = SEL_STATUS;
        MMIO_CYC_LO: sel = SEL_CYC_LO;
        MMIO_CYC_HI: sel = SEL_CYC_HI;
        MMIO_HALT:   sel = SEL_HALT;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel == SEL_RAM && data_we[i]) mem[ram_idx][8*i +: 8] <= data_wdata[8*i +: 8];
    end
  end

  assign fifo_push = (sel == SEL_TXDATA) && data_we[0];
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (data_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  always_comb begin
    status                                        = '0;
    status[STATUS_FULL_BIT]                       = fifo_full;
    status[STATUS_EMPTY_BIT]                      = fifo_empty;
    status[STATUS_OVF_BIT]                        = fifo_ovf;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = STATUS_COUNT_W'(fifo_count);
  end

  // Zero-latency read path: the core consumes data_rdata in the same cycle.
  always_comb begin
    data_rdata = '0;
    case (sel)
      SEL_RAM:    data_rdata = mem[ram_idx];
      SEL_STATUS: data_rdata = status;
      SEL_CYC_LO: data_rdata = cycle[31:0];
      SEL_CYC_HI: data_rdata = cyc_hi_shadow;
      SEL_HALT:   data_rdata = halt_code;
      default:    data_rdata = '0;
    endcase
  end

  // Counter, high-word shadow captured by a CYCLE_LO load, sticky halt and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle         <= '0;
      cyc_hi_shadow <= '0;
      halt          <= 1'b0;
      halt_code     <= '0;
      bus_err       <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (data_re && sel == SEL_CYC_LO) cyc_hi_shadow <= cycle[63:32];
      if (sel == SEL_HALT && data_we != 4'b0000 && !halt) begin
        halt      <= 1'b1;
        halt_code <= data_wdata;
      end
      if (sel == SEL_NONE && access) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed vector table, hand sequences for FIFO/counter/reset
// corners, and random traffic checked against a queue/array reference model.
module tb_dbus_responder;

  localparam int unsigned DEPTH   = 8;
  localparam logic [31:0] A_TX    = 32'h1000_0000;
  localparam logic [31:0] A_ST    = 32'h1000_0004;
  localparam logic [31:0] A_CLO   = 32'h1000_0008;
  localparam logic [31:0] A_CHI   = 32'h1000_000C;
  localparam logic [31:0] A_HALT  = 32'h1000_0010;
  localparam logic [31:0] RAM_END = 32'h0000_4000;

  logic        clk;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic        data_re;
  logic [31:0] data_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        bus_err;

  dbus_responder #(.MEM_WORDS(4096), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_we    (data_we),
    .data_re    (data_re),
    .data_rdata (data_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .halt_code  (halt_code),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] ram_m [4096];
  logic [7:0]  q [$];
  logic        ovf_m, halt_m, err_m;
  logic [31:0] code_m, sh_m;
  logic [63:0] cyc_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic mapped(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (a < RAM_END) || w == A_TX || w == A_ST || w == A_CLO || w == A_CHI || w == A_HALT;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (a < RAM_END) return ram_m[a[13:2]];
    if (w == A_ST)   return {16'h0, 8'(q.size()), 5'b0, ovf_m, q.size() == 0, q.size() == DEPTH};
    if (w == A_CLO)  return cyc_m[31:0];
    if (w == A_CHI)  return sh_m;
    if (w == A_HALT) return code_m;
    return 32'h0;
  endfunction

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0; halt_m = 1'b0; err_m = 1'b0;
    code_m = '0; sh_m = '0; cyc_m = '0;
  endtask

  // One bus cycle: called just after a negedge, returns just after the next negedge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                      input logic re, input logic rdy,
                      output logic [31:0] rd, output logic tv, output logic [7:0] td);
    int sz;
    logic pop, push;
    data_addr = a; data_wdata = wd; data_we = we; data_re = re; tx_ready = rdy;
    #1;
    rd = data_rdata; tv = tx_valid; td = tx_data;
    chk("rdata", rd, model_rdata(a));
    chk("tx_valid", tv, q.size() != 0);
    if (q.size() != 0) chk("tx_data", td, q[0]);
    chk("halt", halt, halt_m);
    chk("halt_code", halt_code, code_m);
    chk("bus_err", bus_err, err_m);
    sz   = q.size();
    pop  = (sz > 0) && rdy;
    push = ({a[31:2], 2'b00} == A_TX) && we[0];
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz == DEPTH && !pop) ovf_m = 1'b1;
      else q.push_back(wd[7:0]);
    end
    if (a < RAM_END)
      for (int i = 0; i < 4; i++) if (we[i]) ram_m[a[13:2]][8*i +: 8] = wd[8*i +: 8];
    if (re && {a[31:2], 2'b00} == A_CLO) sh_m = cyc_m[63:32];
    cyc_m = cyc_m + 64'd1;
    if ({a[31:2], 2'b00} == A_HALT && we != 4'b0 && !halt_m) begin
      halt_m = 1'b1; code_m = wd;
    end
    if (!mapped(a) && (re || we != 4'b0)) err_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        chk_en;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] rd_s;
  logic        tv_s;
  logic [7:0]  td_s;
  logic [7:0]  drain_exp [8];
  logic [31:0] a_r, wd_r;
  logic [3:0]  we_r;
  logic        re_r, rdy_r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    tbl[0]  = '{A_CLO,        32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    tbl[1]  = '{A_CHI,        32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    tbl[2]  = '{32'h100,      32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{32'h100,      32'h11111111, 4'h4, 1'b0, 1'b1, 32'hAABBCCDD};
    tbl[4]  = '{32'h100,      32'h0,        4'h0, 1'b1, 1'b1, 32'hAA11CCDD};
    tbl[5]  = '{32'h102,      32'h0,        4'h0, 1'b1, 1'b1, 32'hAA11CCDD};
    tbl[6]  = '{A_ST,         32'h0,        4'h0, 1'b1, 1'b1, 32'h0000_0002};
    tbl[7]  = '{A_ST,         32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0000_0002};
    tbl[8]  = '{A_TX,         32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    tbl[9]  = '{A_HALT,       32'h1,        4'hF, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{A_HALT,       32'h2,        4'hF, 1'b0, 1'b1, 32'h1};
    tbl[11] = '{32'h2000_0000, 32'h0,       4'h0, 1'b1, 1'b1, 32'h0};
    tbl[12] = '{A_HALT,       32'h0,        4'h0, 1'b1, 1'b1, 32'h1};

    rst = 1'b1; data_addr = A_ST; data_wdata = '0; data_we = '0; data_re = 1'b0; tx_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_halt", halt, 1'b0);
    chk("reset_halt_code", halt_code, 32'h0);
    chk("reset_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // Directed vectors: counter start, RAM lanes, ignored writes, halt, unmapped access
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re, 1'b0, rd_s, tv_s, td_s);
      if (tbl[i].chk_en) chk($sformatf("vec%0d", i), rd_s, tbl[i].exp);
    end
    chk("halt_set", halt, 1'b1);
    chk("halt_code_first", halt_code, 32'h1);
    chk("bus_err_set", bus_err, 1'b1);

    // FIFO fill with overflow, then drain
    for (int i = 0; i < 9; i++) step(A_TX, 32'(8'h41 + i), 4'h1, 1'b0, 1'b0, rd_s, tv_s, td_s);
    step(A_ST, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("status_full_ovf", rd_s, 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      step(A_ST, 32'h0, 4'h0, 1'b0, 1'b1, rd_s, tv_s, td_s);
      chk($sformatf("drain%0d", i), {tv_s, td_s}, {1'b1, 8'(8'h41 + i)});
    end
    step(A_ST, 32'h0, 4'h0, 1'b0, 1'b1, rd_s, tv_s, td_s);
    chk("drain_empty", tv_s, 1'b0);

    // Async reset mid-stream with bytes queued
    for (int i = 0; i < 3; i++) step(A_TX, 32'(8'h61 + i), 4'h1, 1'b0, 1'b0, rd_s, tv_s, td_s);
    data_addr = A_ST; data_we = '0; data_re = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(A_CLO, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cycle_restart", rd_s, 32'h0);
    step(A_CLO, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cycle_first_edge", rd_s, 32'h1);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) step(A_TX, 32'(8'h50 + i), 4'h1, 1'b0, 1'b0, rd_s, tv_s, td_s);
    step(A_TX, 32'h5A, 4'h1, 1'b0, 1'b1, rd_s, tv_s, td_s);
    chk("pushpop_head", td_s, 8'h50);
    step(A_ST, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("status_pushpop_full", rd_s, 32'h0000_0801);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(8'h51 + i);
    drain_exp[7] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step(A_ST, 32'h0, 4'h0, 1'b0, 1'b1, rd_s, tv_s, td_s);
      chk($sformatf("pp_drain%0d", i), {tv_s, td_s}, {1'b1, drain_exp[i]});
    end

    // Coherent high-word read across a low-word wrap
    force dut.cycle = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.cycle;
    cyc_m = 64'h0000_0000_FFFF_FFFE;
    step(A_CLO, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cyc_lo_pre_wrap", rd_s, 32'hFFFF_FFFE);
    step(A_ST, 32'h0, 4'h0, 1'b0, 1'b0, rd_s, tv_s, td_s);
    step(A_CHI, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cyc_hi_coherent", rd_s, 32'h0);
    step(A_CLO, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cyc_lo_post_wrap", rd_s, 32'h1);
    step(A_CHI, 32'h0, 4'h0, 1'b1, 1'b0, rd_s, tv_s, td_s);
    chk("cyc_hi_post_wrap", rd_s, 32'h1);

    // Random traffic against the reference model
    for (int w = 0; w < 64; w++) step(32'(w * 4), $urandom, 4'hF, 1'b0, 1'b0, rd_s, tv_s, td_s);
    for (int i = 0; i < 400; i++) begin
      wd_r = $urandom; we_r = 4'h0; re_r = 1'b0; rdy_r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1: begin a_r = 32'($urandom_range(0, 63) * 4); we_r = 4'($urandom_range(1, 15)); end
        2, 3: begin a_r = 32'($urandom_range(0, 255)) & 32'hFF; re_r = 1'b1; end
        4, 5: begin a_r = A_TX | 32'($urandom_range(0, 3)); we_r = 4'($urandom_range(0, 15)); end
        6:    begin a_r = A_ST; re_r = 1'b1; end
        7:    begin a_r = ($urandom_range(0, 1) != 0) ? A_CLO : A_CHI; re_r = 1'b1; end
        8:    begin a_r = A_HALT; we_r = 4'($urandom_range(0, 15)); re_r = 1'($urandom_range(0, 1)); end
        default: begin
          case ($urandom_range(0, 2))
            0:       a_r = RAM_END;
            1:       a_r = 32'h1000_0014;
            default: a_r = 32'h2000_0000;
          endcase
          re_r = 1'($urandom_range(0, 1));
          we_r = re_r ? 4'h0 : 4'($urandom_range(0, 15));
        end
      endcase
      step(a_r, wd_r, we_r, re_r, rdy_r, rd_s, tv_s, td_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
